update_dispatcher: RTL and testbench

//  Upstream of the arbitrage container. Buffers edge-weight updates (src, dst, weight) from the HPS/bus

---
 rtl/update_dispatcher.sv | 170 +++++++++++++++++
 tb/tb_update_dispatcher.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/update_dispatcher.sv
// update_dispatcher
//   Sits upstream of the arbitrage container. Edge-weight updates written
//   from the HPS/bus path are buffered in a small FIFO. They are then handed
//   to the container one at a time. For each update the block:
//     - presents u_src/u_dst/u_e and latches run_src onto src,
//     - pulses container_reset for one cycle,
//     - waits for container_done before it issues the next update.
//   The update fields stay stable for the whole container run. Writes that
//   arrive while the FIFO is full are counted in drop_cnt. A run that never
//   finishes is abandoned by a watchdog, which sets the sticky timeout flag.
//
// Ports
//   clk              system clock
//   reset            asynchronous, active-high reset
//   wr_valid         update write strobe (one update per cycle)
//   wr_src, wr_dst   update source / destination vertex
//   wr_weight        update weight (log-rate, two's complement)
//   run_src          Bellman source vertex, sampled at each launch
//   wr_full          FIFO full (combinational from the occupancy count)
//   src              container source vertex, held for the run
//   u_src, u_dst     update vertices, held from launch until the run ends
//   u_e              update weight, held from launch until the run ends
//   container_reset  one-cycle launch pulse
//   container_done   container finished (level, stays high until next reset)
//   busy             a run is being launched or awaited
//   drop_cnt         writes lost to a full FIFO, saturating at 255
//   timeout          sticky, set when a run exceeds WDOG cycles
module update_dispatcher #(
  parameter int ADDR_W   = 8,
  parameter int WEIGHT_W = 16,
  parameter int DEPTH    = 8,
  parameter int WDOG     = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic        [ADDR_W-1:0]   wr_src,
  input  logic        [ADDR_W-1:0]   wr_dst,
  input  logic signed [WEIGHT_W-1:0] wr_weight,
  input  logic        [ADDR_W-1:0]   run_src,
  output logic                       wr_full,
  output logic        [ADDR_W-1:0]   src,
  output logic        [ADDR_W-1:0]   u_src,
  output logic        [ADDR_W-1:0]   u_dst,
  output logic signed [WEIGHT_W-1:0] u_e,
  output logic                       container_reset,
  input  logic                       container_done,
  output logic                       busy,
  output logic        [7:0]          drop_cnt,
  output logic                       timeout
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WDOG_W = (WDOG > 1) ? $clog2(WDOG) : 1;

  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(DEPTH);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  // Saturating increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // FIFO storage. Data entries carry no reset. Only pointers and count
  // define which entries are valid.
  logic        [ADDR_W-1:0]   mem_src [DEPTH];
  logic        [ADDR_W-1:0]   mem_dst [DEPTH];
  logic signed [WEIGHT_W-1:0] mem_w   [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic [1:0]        state;
  logic [WDOG_W-1:0] wdog;

  logic fifo_empty;
  logic push;
  logic pop;

  assign fifo_empty = (count == '0);
  assign wr_full    = (count == FULL_CNT);

  // Full is judged on the pre-pop count. A write that coincides with a pop
  // from a full FIFO is therefore still rejected.
  assign push = wr_valid && !wr_full;
  assign pop  = (state == S_IDLE) && !fifo_empty;

  // Both outputs decode straight from the state. An asynchronous reset
  // therefore drops them without waiting for a clock edge.
  assign container_reset = (state == S_LAUNCH);
  assign busy            = (state != S_IDLE);

  // FIFO write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem_src[wr_ptr] <= wr_src;
      mem_dst[wr_ptr] <= wr_dst;
      mem_w[wr_ptr]   <= wr_weight;
    end
  end

  // FIFO pointers, occupancy and drop accounting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_cnt <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      if (wr_valid && wr_full) drop_cnt <= sat_inc8(drop_cnt);
    end
  end

  // Launch sequencer: IDLE -> LAUNCH -> WAIT -> IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      wdog    <= '0;
      timeout <= 1'b0;
      src     <= '0;
      u_src   <= '0;
      u_dst   <= '0;
      u_e     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // The pop and the launch happen on the same edge. The update
          // fields change only here, so they hold across the whole run
          // and through the following idle time.
          if (!fifo_empty) begin
            u_src <= mem_src[rd_ptr];
            u_dst <= mem_dst[rd_ptr];
            u_e   <= mem_w[rd_ptr];
            src   <= run_src;
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // container_done may still be high from the previous run. It is
          // ignored here, and the container clears it on this pulse.
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (container_done) begin
            state <= S_IDLE;
          end else if (wdog == WDOG_LAST) begin
            timeout <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_update_dispatcher.sv
module tb_update_dispatcher;

  localparam int ADDR_W   = 8;
  localparam int WEIGHT_W = 16;
  localparam int DEPTH    = 8;
  localparam int WDOG     = 16;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       wr_valid = 1'b0;
  logic        [ADDR_W-1:0]   wr_src = '0;
  logic        [ADDR_W-1:0]   wr_dst = '0;
  logic signed [WEIGHT_W-1:0] wr_weight = '0;
  logic        [ADDR_W-1:0]   run_src = '0;
  logic                       wr_full;
  logic        [ADDR_W-1:0]   src;
  logic        [ADDR_W-1:0]   u_src;
  logic        [ADDR_W-1:0]   u_dst;
  logic signed [WEIGHT_W-1:0] u_e;
  logic                       container_reset;
  logic                       container_done = 1'b0;
  logic                       busy;
  logic        [7:0]          drop_cnt;
  logic                       timeout;

  update_dispatcher #(
    .ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W), .DEPTH(DEPTH), .WDOG(WDOG)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_src(wr_src),
    .wr_dst(wr_dst), .wr_weight(wr_weight), .run_src(run_src),
    .wr_full(wr_full), .src(src), .u_src(u_src), .u_dst(u_dst), .u_e(u_e),
    .container_reset(container_reset), .container_done(container_done),
    .busy(busy), .drop_cnt(drop_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int d, input int w);
    wr_valid  = 1'b1;
    wr_src    = ADDR_W'(s);
    wr_dst    = ADDR_W'(d);
    wr_weight = WEIGHT_W'(w);
    tick();
    wr_valid  = 1'b0;
  endtask

  // Container stand-in. Each launch takes the next run length from runs.
  // done rises that many cycles after the pulse is seen. A negative length
  // means the container never finishes.
  int runs[$];
  initial begin
    bit cr;
    int cnt;
    int rl;
    bit active;
    active = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      cr = container_reset;
      @(posedge clk);
      #1;
      if (cr) begin
        container_done = 1'b0;
        rl = (runs.size() != 0) ? runs.pop_front() : 3;
        cnt = rl;
        active = (rl > 0);
      end else if (active) begin
        cnt--;
        if (cnt == 0) begin
          container_done = 1'b1;
          active = 1'b0;
        end
      end
    end
  end

  // Behavioural model: a queue of pending updates and the position within
  // the current run (0 = launch cycle, k = k-th cycle spent waiting).
  typedef struct {int s; int d; int w;} upd_t;
  upd_t q[$];
  upd_t cur;
  upd_t nu;
  bit   m_run = 1'b0;
  int   m_age = 0;
  int   m_src = 0, m_us = 0, m_ud = 0, m_ue = 0, m_drop = 0;
  bit   m_to = 1'b0;
  bit   mdl_full;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        q.delete();
        m_run = 1'b0; m_age = 0; m_to = 1'b0; m_drop = 0;
        m_src = 0; m_us = 0; m_ud = 0; m_ue = 0;
      end else begin
        mdl_full = (q.size() == DEPTH);
        if (!m_run) begin
          if (q.size() != 0) begin
            cur = q.pop_front();
            m_us = cur.s; m_ud = cur.d; m_ue = cur.w;
            m_src = run_src;
            m_run = 1'b1;
            m_age = 0;
          end
        end else if (m_age == 0) begin
          m_age = 1;
        end else if (container_done) begin
          m_run = 1'b0;
        end else if (m_age == WDOG) begin
          m_to = 1'b1;
          m_run = 1'b0;
        end else begin
          m_age++;
        end
        if (wr_valid) begin
          if (mdl_full) begin
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
          end else begin
            nu.s = wr_src; nu.d = wr_dst; nu.w = wr_weight;
            q.push_back(nu);
          end
        end
      end
    end
  end

  // Observation log plus the per-cycle comparison against the model.
  int p_us[$], p_ud[$], p_ue[$], p_src[$], p_cyc[$];
  int busy_cyc = 0;
  int to_rise  = -1;

  initial begin
    bit r;
    forever begin
      @(negedge clk);
      cyc++;
      if (container_reset) begin
        p_us.push_back(u_src); p_ud.push_back(u_dst); p_ue.push_back(u_e);
        p_src.push_back(src);  p_cyc.push_back(cyc);
      end
      if (busy) busy_cyc++;
      if (timeout && to_rise < 0) to_rise = cyc;
      r = reset;
      chk("wr_full",         wr_full,         r ? 0 : int'(q.size() == DEPTH));
      chk("src",             src,             r ? 0 : m_src);
      chk("u_src",           u_src,           r ? 0 : m_us);
      chk("u_dst",           u_dst,           r ? 0 : m_ud);
      chk("u_e",             u_e,             r ? 0 : m_ue);
      chk("container_reset", container_reset, r ? 0 : int'(m_run && m_age == 0));
      chk("busy",            busy,            r ? 0 : int'(m_run));
      chk("drop_cnt",        drop_cnt,        r ? 0 : m_drop);
      chk("timeout",         timeout,         r ? 0 : int'(m_to));
    end
  end

  initial begin
    #1 reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_u_src", u_src, 0);
    chk("rst_full", wr_full, 0);

    // Single update with a 10-cycle container run
    runs.push_back(10);
    run_src = 8'd7;
    wr(3, 5, -20);
    repeat (20) tick();
    chk("t1_pulses", p_cyc.size(), 1);
    chk("t1_busy_cycles", busy_cyc, 12);
    chk("t1_u_src", p_us[0], 3);
    chk("t1_u_dst", p_ud[0], 5);
    chk("t1_u_e", p_ue[0], -20);
    chk("t1_src", p_src[0], 7);

    // One long run while 8 more updates fill the FIFO, then 3 are dropped
    runs.push_back(14);
    repeat (8) runs.push_back(2);
    run_src = 8'd9;
    for (int i = 0; i < 12; i++) wr(10 + i, 50 + i, -100 + i * 7);
    chk("t3_drop_now", drop_cnt, 3);
    chk("t2_full_now", wr_full, 1);
    repeat (90) tick();
    chk("t2_pulses", p_cyc.size(), 10);
    for (int i = 0; i < 9; i++) begin
      chk("t2_order_src", p_us[1 + i], 10 + i);
      chk("t2_order_dst", p_ud[1 + i], 50 + i);
      chk("t2_order_e",   p_ue[1 + i], -100 + i * 7);
    end
    chk("t3_drop_final", drop_cnt, 3);
    chk("t2_full_drained", wr_full, 0);

    // Container never finishes: watchdog abandons the run
    runs.push_back(-1);
    runs.push_back(2);
    run_src = 8'd4;
    wr(30, 31, -1);
    wr(32, 33, 5);
    repeat (40) tick();
    chk("t5_pulses", p_cyc.size(), 12);
    chk("t5_hung_src", p_us[10], 30);
    chk("t5_next_src", p_us[11], 32);
    chk("t5_timeout", timeout, 1);
    chk("t5_timeout_at", to_rise - p_cyc[10], 17);
    chk("t5_next_launch", p_cyc[11] - p_cyc[10], 18);

    // Reset in the middle of a run with 4 entries queued
    runs.push_back(10);
    run_src = 8'd2;
    for (int i = 0; i < 5; i++) wr(40 + i, 60 + i, i);
    repeat (2) tick();
    chk("t6_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_pulse", container_reset, 0);
    chk("t6_u_src", u_src, 0);
    chk("t6_u_e", u_e, 0);
    chk("t6_src", src, 0);
    chk("t6_timeout", timeout, 0);
    chk("t6_pulses", p_cyc.size(), 13);
    tick();
    tick();
    reset = 1'b0;
    repeat (30) tick();
    chk("t6_no_more_pulses", p_cyc.size(), 13);
    chk("t6_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
